// File: rtl/timer_pulse_meter.sv
// timer_pulse_meter: measures one high-time and one full period of the
// asynchronous 555 timer output in clk cycles. The results are held behind a
// valid/ack handshake and read out one byte at a time.
//
// Optional feature: define TIMER_PULSE_METER_TIMEOUT_EN to build a watchdog.
// The watchdog aborts a measurement that sees no timer edge for 2^CNT_W-1
// cycles.
//
// Parameters: CNT_W (8..16) counter width; SYNC_STAGES (>=2) synchronizer depth.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   timer_in    raw 555 output (asynchronous)
//   start       arm a measurement (sampled only in IDLE)
//   ack         release held results (sampled only in DONE)
//   rd_sel      readout byte select: 0/1 high_cnt lo/hi, 2/3 period_cnt lo/hi
//   rd_data     selected result byte (combinational from result registers)
//   busy        measurement in progress
//   valid       results held
//   ovf         a counter saturated during this measurement
//   timeout     last measurement aborted by the watchdog (0 if not built)
module timer_pulse_meter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       timer_in,
   input  logic       start,
   input  logic       ack,
   input  logic [1:0] rd_sel,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       valid,
   output logic       ovf,
   output logic       timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_RISE = 3'd1,
      S_MEAS_HIGH = 3'd2,
      S_MEAS_LOW  = 3'd3,
      S_DONE      = 3'd4
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       high_q, high_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic                   ovf_q, ovf_d;
   logic                   busy_q, busy_d;
   logic                   valid_q, valid_d;
   logic                   sync_c, rise_c, fall_c;
   logic                   sat_c;
   logic [CNT_W-1:0]       cnt_inc_c;
   logic [15:0]            high_ext_c, period_ext_c;

`ifdef TIMER_PULSE_METER_TIMEOUT_EN
   localparam logic [CNT_W-1:0] WD_LAST = CNT_MAX - CNT_W'(1);
   logic [CNT_W-1:0] wd_q, wd_d;
   logic             timeout_q, timeout_d;
`endif

   // Edge detection on the synchronized level; prev_q tracks it every cycle.
   assign sync_c    = sync_q[SYNC_STAGES-1];
   assign rise_c    = sync_c & ~prev_q;
   assign fall_c    = ~sync_c & prev_q;

   // Saturating increment of the shared measurement counter.
   assign sat_c     = (cnt_q == CNT_MAX);
   assign cnt_inc_c = sat_c ? cnt_q : cnt_q + CNT_W'(1);

   // Next-state and datapath logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      high_d   = high_q;
      period_d = period_q;
      ovf_d    = ovf_q;
`ifdef TIMER_PULSE_METER_TIMEOUT_EN
      wd_d      = wd_q;
      timeout_d = timeout_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_WAIT_RISE;
               high_d   = '0;
               period_d = '0;
               ovf_d    = 1'b0;
`ifdef TIMER_PULSE_METER_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
            end
         end
         S_WAIT_RISE: begin
            // Counter starts at 1 so the capture equals the strobe distance.
            if (rise_c) begin
               cnt_d   = CNT_W'(1);
               state_d = S_MEAS_HIGH;
            end
         end
         S_MEAS_HIGH: begin
            cnt_d = cnt_inc_c;
            if (sat_c) ovf_d = 1'b1;
            if (fall_c) begin
               high_d  = cnt_q;
               state_d = S_MEAS_LOW;
            end
         end
         S_MEAS_LOW: begin
            if (rise_c) begin
               period_d = cnt_q;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_inc_c;
               if (sat_c) ovf_d = 1'b1;
            end
         end
         S_DONE: begin
            if (ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef TIMER_PULSE_METER_TIMEOUT_EN
      // Watchdog: any edge restarts it; reaching the limit aborts to IDLE.
      if (state_q == S_IDLE) begin
         wd_d = '0;
      end else if (state_q != S_DONE) begin
         if (rise_c || fall_c) begin
            wd_d = '0;
         end else if (wd_q == WD_LAST) begin
            wd_d      = '0;
            state_d   = S_IDLE;
            timeout_d = 1'b1;
         end else begin
            wd_d = wd_q + CNT_W'(1);
         end
      end
`endif

      busy_d  = (state_d == S_WAIT_RISE) || (state_d == S_MEAS_HIGH) ||
                (state_d == S_MEAS_LOW);
      valid_d = (state_d == S_DONE);
   end

   // State, synchronizer and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sync_q   <= '0;
         prev_q   <= 1'b0;
         cnt_q    <= '0;
         high_q   <= '0;
         period_q <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
`ifdef TIMER_PULSE_METER_TIMEOUT_EN
         wd_q      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], timer_in};
         prev_q   <= sync_c;
         cnt_q    <= cnt_d;
         high_q   <= high_d;
         period_q <= period_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
`ifdef TIMER_PULSE_METER_TIMEOUT_EN
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   // Byte readout of the zero-extended results.
   assign high_ext_c   = 16'(high_q);
   assign period_ext_c = 16'(period_q);

   always_comb begin
      rd_data = 8'h00;
      unique case (rd_sel)
         2'd0: rd_data = high_ext_c[7:0];
         2'd1: rd_data = high_ext_c[15:8];
         2'd2: rd_data = period_ext_c[7:0];
         2'd3: rd_data = period_ext_c[15:8];
         default: rd_data = 8'h00;
      endcase
   end

   assign busy  = busy_q;
   assign valid = valid_q;
   assign ovf   = ovf_q;
`ifdef TIMER_PULSE_METER_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule
